ex_muldiv_seq: RTL

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

---
 rtl/ex_muldiv_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - sequential MIPS-style mul/div unit with HI/LO and pipeline stall
// One iteration per clock: shift-add multiply or restoring divide, then a sign-fix cycle.
module ex_muldiv_seq #(
    parameter int NB_REG = 32,
    parameter int NB_CNT = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [NB_REG-1:0] i_rs_data,
    input  logic [NB_REG-1:0] i_rt_data,
    input  logic              i_hilo_req,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic [NB_REG-1:0] o_hi,
    output logic [NB_REG-1:0] o_lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]          state;
    logic [1:0]          op_r;
    logic                sign_a;
    logic                sign_b;
    logic [NB_REG-1:0]   mag_b;
    logic [NB_CNT-1:0]   cnt;
    logic [2*NB_REG-1:0] acc;
    logic [NB_REG-1:0]   hi_r;
    logic [NB_REG-1:0]   lo_r;
    logic                done_r;

    logic                rs_neg;
    logic                rt_neg;
    logic [NB_REG-1:0]   rs_mag;
    logic [NB_REG-1:0]   rt_mag;
    logic [NB_REG:0]     mul_sum;
    logic [2*NB_REG-1:0] mul_next;
    logic [NB_REG:0]     div_shift;
    logic [NB_REG+1:0]   div_diff;
    logic [2*NB_REG-1:0] div_next;
    logic [2*NB_REG-1:0] mul_res;
    logic [NB_REG-1:0]   quo;
    logic [NB_REG-1:0]   rem;
    logic [NB_REG-1:0]   div_lo;
    logic [NB_REG-1:0]   div_hi;

    // op[0]=1 selects the unsigned variant, op[1]=1 selects divide
    always_comb begin
        rs_neg = ~i_op[0] & i_rs_data[NB_REG-1];
        rt_neg = ~i_op[0] & i_rt_data[NB_REG-1];
        rs_mag = rs_neg ? -i_rs_data : i_rs_data;
        rt_mag = rt_neg ? -i_rt_data : i_rt_data;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*NB_REG-1:NB_REG]} + (acc[0] ? {1'b0, mag_b} : '0);
        mul_next  = {mul_sum, acc[NB_REG-1:1]};
        div_shift = acc[2*NB_REG-1:NB_REG-1];
        div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
        if (div_diff[NB_REG+1])
            div_next = {div_shift[NB_REG-1:0], acc[NB_REG-2:0], 1'b0};
        else
            div_next = {div_diff[NB_REG-1:0], acc[NB_REG-2:0], 1'b1};
    end

    // Divide by zero falls out of the loop as remainder = |rs|, so only LO is forced
    always_comb begin
        mul_res = (sign_a ^ sign_b) ? -acc : acc;
        quo     = acc[NB_REG-1:0];
        rem     = acc[2*NB_REG-1:NB_REG];
        div_lo  = (mag_b == '0) ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
        div_hi  = sign_a ? -rem : rem;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            op_r   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_b  <= '0;
            cnt    <= '0;
            acc    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_flush) begin
                        op_r   <= i_op;
                        sign_a <= rs_neg;
                        sign_b <= rt_neg;
                        cnt    <= '0;
                        if (i_op[1]) begin
                            mag_b <= rt_mag;
                            acc   <= {{NB_REG{1'b0}}, rs_mag};
                        end else begin
                            mag_b <= rs_mag;
                            acc   <= {{NB_REG{1'b0}}, rt_mag};
                        end
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= op_r[1] ? div_next : mul_next;
                        cnt <= cnt + NB_CNT'(1);
                        if (cnt == NB_CNT'(NB_REG - 1))
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!i_flush) begin
                        if (op_r[1]) begin
                            hi_r <= div_hi;
                            lo_r <= div_lo;
                        end else begin
                            hi_r <= mul_res[2*NB_REG-1:NB_REG];
                            lo_r <= mul_res[NB_REG-1:0];
                        end
                        done_r <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_stall = o_busy & (i_start | i_hilo_req);
    assign o_done  = done_r;
    assign o_hi    = hi_r;
    assign o_lo    = lo_r;

endmodule
